// File: rtl/pc_seq_unit_if.sv
// pc_seq_unit_if: decoder/ALU-side bundle for the program-counter sequencer.
//
// Signals (direction as seen from the sequencer, i.e. the slave modport):
//   stall          in   freeze all sequencer state for the cycle
//   pc_sel         in   00 increment, 01 branch, 10 jump, 11 jump-register
//   is_true        in   branch condition, only meaningful when pc_sel = 01
//   extended_imm   in   sign-extended 16-bit immediate
//   j_addr         in   instruction[25:0]
//   reg_data_a     in   rs value for JR/JALR
//   pc             out  address of the instruction currently executing
//   link_pc        out  pc + 8, return address for linking instructions
//   in_delay_slot  out  current instruction sits in a branch delay slot
//   active         out  1 while running, 0 once halted
//   ds_violation   out  one-cycle pulse: transfer executed inside a delay slot
//   addr_err       out  sticky misaligned-JR flag (only with PC_ALIGN_CHECK_EN)
//
// Optional feature macro: PC_ALIGN_CHECK_EN adds addr_err.
interface pc_seq_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              stall;
    logic [1:0]        pc_sel;
    logic              is_true;
    logic [31:0]       extended_imm;
    logic [25:0]       j_addr;
    logic [31:0]       reg_data_a;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] link_pc;
    logic              in_delay_slot;
    logic              active;
    logic              ds_violation;
`ifdef PC_ALIGN_CHECK_EN
    logic              addr_err;
`endif

    // Decoder/ALU side.
    modport master (
        output stall, pc_sel, is_true, extended_imm, j_addr, reg_data_a,
        input  pc, link_pc, in_delay_slot, active, ds_violation
`ifdef PC_ALIGN_CHECK_EN
        , input addr_err
`endif
    );

    // Sequencer side.
    modport slave (
        input  stall, pc_sel, is_true, extended_imm, j_addr, reg_data_a,
        output pc, link_pc, in_delay_slot, active, ds_violation
`ifdef PC_ALIGN_CHECK_EN
        , output addr_err
`endif
    );
endinterface

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: MIPS program-counter register with architectural branch delay slot,
// stall, parametrised reset vector and halt-on-transfer-to-HALT_ADDR detection.
//
// Ports:
//   clk     in     rising-edge system clock
//   rst_n   in     asynchronous active-low reset
//   pc_bus  slave  pc_seq_unit_if bundle (stall, pc_sel, is_true, extended_imm,
//                  j_addr, reg_data_a in; pc, link_pc, in_delay_slot, active,
//                  ds_violation [, addr_err] out)
//
// Parameters:
//   ADDR_W        PC width, supported range 28..32 (must match the interface)
//   RESET_VECTOR  PC loaded on reset, truncated to ADDR_W
//   HALT_ADDR     a taken transfer landing here halts execution
//
// Optional feature macro: PC_ALIGN_CHECK_EN. When defined, a JR whose target has
// nonzero low bits halts at the delay slot instead of redirecting and raises a
// sticky addr_err. When undefined, those low bits are silently dropped.
module pc_seq_unit #(
    parameter int unsigned ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst_n,
    pc_seq_unit_if.slave pc_bus
);

    localparam logic [ADDR_W-1:0] ResetPc  = RESET_VECTOR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] HaltAddr = HALT_ADDR[ADDR_W-1:0];

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDelay  = 2'd1,
        StHalted = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              ds_viol_q, ds_viol_d;
`ifdef PC_ALIGN_CHECK_EN
    logic              misalign_q, misalign_d;
    logic              addr_err_q, addr_err_d;
`endif

    logic [ADDR_W-1:0] pc_plus4;
    logic [33:0]       imm_shift;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] jump_tgt;
    logic [ADDR_W-1:0] jr_tgt;
    logic              slot_xfer;
    logic              unused_inputs;

    // All targets are relative to the PC of the transfer instruction itself.
    assign pc_plus4   = pc_q + ADDR_W'(4);
    assign imm_shift  = {pc_bus.extended_imm, 2'b00};
    assign branch_tgt = pc_plus4 + imm_shift[ADDR_W-1:0];
    assign jr_tgt     = {pc_bus.reg_data_a[ADDR_W-1:2], 2'b00};

    generate
        if (ADDR_W > 28) begin : g_jump_seg
            assign jump_tgt = {pc_plus4[ADDR_W-1:28], pc_bus.j_addr, 2'b00};
        end else begin : g_jump_noseg
            assign jump_tgt = {pc_bus.j_addr, 2'b00};
        end
    endgenerate

    // A transfer that would actually be taken; an untaken branch is harmless in a slot.
    assign slot_xfer = pc_bus.pc_sel[1] | (pc_bus.pc_sel[0] & pc_bus.is_true);

    // Bits of the wide inputs that fall outside the PC width are intentionally ignored.
    assign unused_inputs = ^{pc_bus.extended_imm, pc_bus.reg_data_a};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        target_d  = target_q;
        ds_viol_d = 1'b0;  // one-cycle pulse, clears even while stalled
`ifdef PC_ALIGN_CHECK_EN
        misalign_d = misalign_q;
        addr_err_d = addr_err_q;
`endif
        if (!pc_bus.stall) begin
            case (state_q)
                StRun: begin
                    pc_d = pc_plus4;
                    case (pc_bus.pc_sel)
                        2'b01: begin
                            if (pc_bus.is_true) begin
                                target_d = branch_tgt;
                                state_d  = StDelay;
`ifdef PC_ALIGN_CHECK_EN
                                misalign_d = 1'b0;
`endif
                            end
                        end
                        2'b10: begin
                            target_d = jump_tgt;
                            state_d  = StDelay;
`ifdef PC_ALIGN_CHECK_EN
                            misalign_d = 1'b0;
`endif
                        end
                        2'b11: begin
                            target_d = jr_tgt;
                            state_d  = StDelay;
`ifdef PC_ALIGN_CHECK_EN
                            misalign_d = |pc_bus.reg_data_a[1:0];
`endif
                        end
                        default: ;
                    endcase
                end
                StDelay: begin
                    // The slot instruction executes, but its own pc_sel never redirects.
                    ds_viol_d = slot_xfer;
`ifdef PC_ALIGN_CHECK_EN
                    if (misalign_q) begin
                        pc_d       = pc_q;
                        state_d    = StHalted;
                        addr_err_d = 1'b1;
                    end else
`endif
                    begin
                        pc_d    = target_q;
                        state_d = (target_q == HaltAddr) ? StHalted : StRun;
                    end
                end
                StHalted: ;
                default: state_d = StHalted;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            pc_q      <= ResetPc;
            target_q  <= '0;
            ds_viol_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
            addr_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            target_q  <= target_d;
            ds_viol_q <= ds_viol_d;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
            addr_err_q <= addr_err_d;
`endif
        end
    end

    assign pc_bus.pc            = pc_q;
    assign pc_bus.link_pc       = pc_q + ADDR_W'(8);
    assign pc_bus.in_delay_slot = (state_q == StDelay);
    assign pc_bus.active        = (state_q != StHalted);
    assign pc_bus.ds_violation  = ds_viol_q;
`ifdef PC_ALIGN_CHECK_EN
    assign pc_bus.addr_err      = addr_err_q;
`endif

endmodule
